// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory: access sizes, controller states, size decode.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/dmem_extend.sv
// Sign/zero extension of gathered little-endian load bytes to the full data width.
module dmem_extend
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] raw,
   input  logic [1:0]        size,
   input  logic              sgn,
   output logic [DATA_W-1:0] data
);

   localparam int TW = $clog2(DATA_W);

   logic [TW-1:0] top;
   logic          fill;

   always_comb begin
      case (size)
         SZ_B:    top = TW'(7);
         SZ_H:    top = TW'(15);
         SZ_W:    top = TW'(31);
         default: top = TW'(DATA_W - 1);
      endcase
      fill = sgn & raw[top];
      data = '0;
      for (int i = 0; i < DATA_W; i++)
         data[i] = (i <= int'(top)) ? raw[i] : fill;
   end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with valid/ready handshake and range checking.
// Define DATA_MEM_ALIGN_CHECK_EN to also reject accesses not aligned to their size.
//
//  state | meaning
//  IDLE  | ready for a request; acceptance commits stores and samples loads
//  WAIT  | counting out the remaining read latency
//  RESP  | response presented, held until rsp_ready
module data_mem
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_BYTES = 1024,
   parameter int RD_LAT      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam int NB = DATA_W / 8;
   localparam int IW = $clog2(DEPTH_BYTES);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

   reg [7:0] mem [DEPTH_BYTES-1:0];

   state_t            state;
   logic [1:0]        cnt;
   logic [DATA_W-1:0] raw_q;
   logic [1:0]        size_q;
   logic              sgn_q;

   logic              accept;
   logic              err;
   logic [3:0]        n;
   logic [ADDR_W:0]   end_addr;
   logic [IW-1:0]     base;
   logic [DATA_W-1:0] gather;

   assign accept   = req_valid && req_ready;
   assign n        = size_bytes(req_size);
   // One extra bit so an access running past the top of the address space cannot wrap.
   assign end_addr = {1'b0, req_addr} + (ADDR_W + 1)'(n);
   assign base     = req_addr[IW-1:0];

   always_comb begin
      err = (end_addr > DEPTH_L);
      if (req_size == SZ_D && DATA_W == 32)
         err = 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
      if ((req_addr[3:0] & (n - 4'd1)) != 4'd0)
         err = 1'b1;
`else
`endif
   end

   always_comb begin
      gather = '0;
      for (int i = 0; i < NB; i++)
         if (i < int'(n))
            gather[8*i +: 8] = mem[base + IW'(i)];
   end

   always_ff @(posedge clk) begin
      if (accept && req_we && !err)
         for (int i = 0; i < NB; i++)
            if (i < int'(n))
               mem[base + IW'(i)] <= req_wdata[8*i +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         raw_q     <= '0;
         size_q    <= SZ_B;
         sgn_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  // Stores and rejected accesses return zero data.
                  raw_q     <= (req_we || err) ? '0 : gather;
                  size_q    <= req_size;
                  sgn_q     <= req_signed;
                  rsp_err   <= err;
                  if (RD_LAT == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                  end else begin
                     state <= WAIT;
                     cnt   <= 2'(RD_LAT - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   dmem_extend #(.DATA_W(DATA_W)) u_extend (
      .raw  (raw_q),
      .size (size_q),
      .sgn  (sgn_q),
      .data (rsp_rdata)
   );

endmodule
